// File: rtl/trivial_timer_if.sv
// AXI4-Lite style register bus for trivial_timer: 16-bit addresses, 32-bit data,
// fixed OKAY responses. The master modport is the bus driver; the slave modport is the timer.
interface trivial_timer_if;
    logic        AWVALID;
    logic        AWREADY;
    logic [15:0] AWADDR;
    logic [1:0]  AWPROT;
    logic        WVALID;
    logic        WREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        BVALID;
    logic        BREADY;
    logic [2:0]  BRESP;
    logic        ARVALID;
    logic        ARREADY;
    logic [15:0] ARADDR;
    logic [1:0]  ARPROT;
    logic        RVALID;
    logic        RREADY;
    logic [31:0] RDATA;
    logic [2:0]  RRESP;

    modport master (
        output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
               ARVALID, ARADDR, ARPROT, RREADY,
        input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );

    modport slave (
        input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
               ARVALID, ARADDR, ARPROT, RREADY,
        output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );
endinterface

// File: rtl/trivial_timer.sv
// Programmable down-counting timer behind an AXI4-Lite register interface,
// with a sticky expiry flag driving one level-sensitive interrupt.
module trivial_timer #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic           ACLK,
    input  logic           ARESET,
    output logic           irq,
    trivial_timer_if.slave s_axi
);

    localparam logic [15:0] ADDR_CTRL   = 16'h0000;
    localparam logic [15:0] ADDR_LOAD   = 16'h0004;
    localparam logic [15:0] ADDR_COUNT  = 16'h0008;
    localparam logic [15:0] ADDR_STATUS = 16'h000C;
    localparam logic [15:0] PS_MAX      = 16'(PRESCALE - 1);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    // ARESET asserts immediately but is released two clock edges later.
    logic [1:0] rst_pipe_q;
    logic       rst;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) rst_pipe_q <= 2'b11;
        else        rst_pipe_q <= {rst_pipe_q[0], 1'b0};
    end
    assign rst = rst_pipe_q[1];

    wstate_t     wstate_q;
    logic        awready_q, wready_q, bvalid_q;
    logic [15:0] awaddr_q;
    rstate_t     rstate_q;
    logic        arready_q, rvalid_q;
    logic [31:0] rdata_q;

    logic        en_q, en_d, reload_q, reload_d, ie_q, ie_d;
    logic        exp_q, exp_d, irq_q, irq_d;
    logic [31:0] load_q, load_d, count_q, count_d;
    logic [15:0] prescale_q, prescale_d;
    logic [31:0] rd_val;
    logic        wr_en, tick, exp_set, exp_clr;
    logic        unused_inputs;

    assign unused_inputs = ^{s_axi.AWPROT, s_axi.WSTRB, s_axi.ARPROT};

    always_ff @(posedge ACLK or posedge rst) begin
        if (rst) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            awaddr_q  <= '0;
        end else begin
            case (wstate_q)
                W_IDLE: if (s_axi.AWVALID) begin
                    awaddr_q  <= s_axi.AWADDR;
                    awready_q <= 1'b0;
                    wready_q  <= 1'b1;
                    wstate_q  <= W_DATA;
                end
                W_DATA: if (s_axi.WVALID) begin
                    wready_q <= 1'b0;
                    bvalid_q <= 1'b1;
                    wstate_q <= W_RESP;
                end
                W_RESP: if (s_axi.BREADY) begin
                    bvalid_q  <= 1'b0;
                    awready_q <= 1'b1;
                    wstate_q  <= W_IDLE;
                end
                default: begin
                    awready_q <= 1'b1;
                    wready_q  <= 1'b0;
                    bvalid_q  <= 1'b0;
                    wstate_q  <= W_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge ACLK or posedge rst) begin
        if (rst) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (rstate_q)
                R_IDLE: if (s_axi.ARVALID) begin
                    rdata_q   <= rd_val;
                    arready_q <= 1'b0;
                    rvalid_q  <= 1'b1;
                    rstate_q  <= R_DATA;
                end
                R_DATA: if (s_axi.RREADY) begin
                    rvalid_q  <= 1'b0;
                    arready_q <= 1'b1;
                    rstate_q  <= R_IDLE;
                end
                default: begin
                    arready_q <= 1'b1;
                    rvalid_q  <= 1'b0;
                    rstate_q  <= R_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        rd_val = '0;
        case (s_axi.ARADDR)
            ADDR_CTRL:   rd_val = {29'b0, ie_q, reload_q, en_q};
            ADDR_LOAD:   rd_val = load_q;
            ADDR_COUNT:  rd_val = count_q;
            ADDR_STATUS: rd_val = {31'b0, exp_q};
            default:     rd_val = '0;
        endcase
    end

    assign wr_en = wready_q && s_axi.WVALID;
    assign tick  = en_q && (prescale_q == PS_MAX);

    // Timer events are applied first so a same-edge software write overrides them,
    // except that an expiry always beats a STATUSR clear.
    always_comb begin
        en_d       = en_q;
        reload_d   = reload_q;
        ie_d       = ie_q;
        load_d     = load_q;
        count_d    = count_q;
        exp_set    = 1'b0;
        exp_clr    = 1'b0;
        prescale_d = (!en_q || tick) ? 16'd0 : prescale_q + 16'd1;

        if (tick) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else begin
                exp_set = 1'b1;
                if (reload_q) count_d = load_q;
                else          en_d    = 1'b0;
            end
        end

        if (wr_en) begin
            case (awaddr_q)
                ADDR_CTRL:   {ie_d, reload_d, en_d} = s_axi.WDATA[2:0];
                ADDR_LOAD:   load_d  = s_axi.WDATA;
                ADDR_COUNT:  count_d = s_axi.WDATA;
                ADDR_STATUS: exp_clr = s_axi.WDATA[0];
                default:     ;
            endcase
        end

        exp_d = exp_set | (exp_q & ~exp_clr);
        irq_d = exp_q & ie_q;
    end

    always_ff @(posedge ACLK or posedge rst) begin
        if (rst) begin
            en_q       <= 1'b0;
            reload_q   <= 1'b0;
            ie_q       <= 1'b0;
            load_q     <= '0;
            count_q    <= '0;
            exp_q      <= 1'b0;
            irq_q      <= 1'b0;
            prescale_q <= '0;
        end else begin
            en_q       <= en_d;
            reload_q   <= reload_d;
            ie_q       <= ie_d;
            load_q     <= load_d;
            count_q    <= count_d;
            exp_q      <= exp_d;
            irq_q      <= irq_d;
            prescale_q <= prescale_d;
        end
    end

    assign s_axi.AWREADY = awready_q;
    assign s_axi.WREADY  = wready_q;
    assign s_axi.BVALID  = bvalid_q;
    assign s_axi.BRESP   = 3'b000;
    assign s_axi.ARREADY = arready_q;
    assign s_axi.RVALID  = rvalid_q;
    assign s_axi.RDATA   = rdata_q;
    assign s_axi.RRESP   = 3'b000;
    assign irq           = irq_q;

endmodule

// File: tb/tb_trivial_timer.sv
// Bench for trivial_timer: two instances (PRESCALE 1 and 4) share one bus stimulus
// and are compared every cycle against a behavioural model of the register map.
module tb_trivial_timer;

    logic ACLK   = 1'b0;
    logic ARESET = 1'b0;
    logic irq1, irq4;

    always #5 ACLK = ~ACLK;

    logic        aw_valid = 0, w_valid = 0, b_ready = 0, ar_valid = 0, r_ready = 0;
    logic [15:0] aw_addr = 0, ar_addr = 0;
    logic [31:0] w_data = 0;
    logic [1:0]  aw_prot = 0, ar_prot = 0;
    logic [3:0]  w_strb = 0;

    trivial_timer_if if1 ();
    trivial_timer_if if4 ();

    assign if1.AWVALID = aw_valid;  assign if4.AWVALID = aw_valid;
    assign if1.AWADDR  = aw_addr;   assign if4.AWADDR  = aw_addr;
    assign if1.AWPROT  = aw_prot;   assign if4.AWPROT  = aw_prot;
    assign if1.WVALID  = w_valid;   assign if4.WVALID  = w_valid;
    assign if1.WDATA   = w_data;    assign if4.WDATA   = w_data;
    assign if1.WSTRB   = w_strb;    assign if4.WSTRB   = w_strb;
    assign if1.BREADY  = b_ready;   assign if4.BREADY  = b_ready;
    assign if1.ARVALID = ar_valid;  assign if4.ARVALID = ar_valid;
    assign if1.ARADDR  = ar_addr;   assign if4.ARADDR  = ar_addr;
    assign if1.ARPROT  = ar_prot;   assign if4.ARPROT  = ar_prot;
    assign if1.RREADY  = r_ready;   assign if4.RREADY  = r_ready;

    trivial_timer #(.PRESCALE(1)) dut1 (.ACLK(ACLK), .ARESET(ARESET), .irq(irq1), .s_axi(if1.slave));
    trivial_timer #(.PRESCALE(4)) dut4 (.ACLK(ACLK), .ARESET(ARESET), .irq(irq4), .s_axi(if4.slave));

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural model: index 0 is the PRESCALE=1 timer, index 1 the PRESCALE=4 timer.
    int          ps [2] = '{1, 4};
    logic [31:0] m_count [2], m_load [2], m_rdata [2];
    bit          m_en [2], m_rel [2], m_ie [2], m_exp [2], m_irq [2];
    int          m_phase [2];
    int          m_wph = 0, m_rph = 0;
    logic [15:0] m_waddr = 0;
    int          cyc = 0, wfire_cyc = 0;

    function automatic logic [31:0] model_read(int p, logic [15:0] a);
        case (a)
            16'h0000: return {29'b0, m_ie[p], m_rel[p], m_en[p]};
            16'h0004: return m_load[p];
            16'h0008: return m_count[p];
            16'h000C: return {31'b0, m_exp[p]};
            default:  return 32'd0;
        endcase
    endfunction

    always @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            m_wph = 0; m_rph = 0; m_waddr = 0;
            for (int p = 0; p < 2; p++) begin
                m_count[p] = 0; m_load[p] = 0; m_rdata[p] = 0; m_phase[p] = 0;
                m_en[p] = 0; m_rel[p] = 0; m_ie[p] = 0; m_exp[p] = 0; m_irq[p] = 0;
            end
        end else begin
            bit wfire, tick, expire, clr;
            cyc++;
            wfire = (m_wph == 1) && w_valid;
            if (wfire) wfire_cyc = cyc;
            for (int p = 0; p < 2; p++) begin
                if (m_rph == 0 && ar_valid) m_rdata[p] = model_read(p, ar_addr);
                m_irq[p]   = m_exp[p] & m_ie[p];
                tick       = m_en[p] && (m_phase[p] == ps[p] - 1);
                m_phase[p] = m_en[p] ? (m_phase[p] + 1) % ps[p] : 0;
                expire     = tick && (m_count[p] == 0);
                if (tick) begin
                    if (m_count[p] != 0) m_count[p] = m_count[p] - 1;
                    else if (m_rel[p])   m_count[p] = m_load[p];
                    else                 m_en[p]    = 0;
                end
                clr = wfire && (m_waddr == 16'h000C) && w_data[0];
                if (wfire) begin
                    case (m_waddr)
                        16'h0000: begin m_en[p] = w_data[0]; m_rel[p] = w_data[1]; m_ie[p] = w_data[2]; end
                        16'h0004: m_load[p]  = w_data;
                        16'h0008: m_count[p] = w_data;
                        default: ;
                    endcase
                end
                m_exp[p] = expire | (m_exp[p] & !clr);
            end
            case (m_wph)
                0: if (aw_valid) begin m_wph = 1; m_waddr = aw_addr; end
                1: if (w_valid) m_wph = 2;
                default: if (b_ready) m_wph = 0;
            endcase
            if (m_rph == 0) begin
                if (ar_valid) m_rph = 1;
            end else if (r_ready) m_rph = 0;
        end
    end

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_err++;
        $display("[TB] FAIL %s: timeout, got no event, expected one within budget", name);
    endtask

    task automatic check_dut(input string tag, input int p, input logic awr, input logic wr,
                             input logic bv, input logic [2:0] br, input logic arr, input logic rv,
                             input logic [31:0] rd, input logic [2:0] rr, input logic iq);
        check_output({tag, ".awready"}, {31'b0, awr}, {31'b0, m_wph == 0});
        check_output({tag, ".wready"},  {31'b0, wr},  {31'b0, m_wph == 1});
        check_output({tag, ".bvalid"},  {31'b0, bv},  {31'b0, m_wph == 2});
        check_output({tag, ".bresp"},   {29'b0, br},  32'd0);
        check_output({tag, ".arready"}, {31'b0, arr}, {31'b0, m_rph == 0});
        check_output({tag, ".rvalid"},  {31'b0, rv},  {31'b0, m_rph == 1});
        check_output({tag, ".rresp"},   {29'b0, rr},  32'd0);
        check_output({tag, ".irq"},     {31'b0, iq},  {31'b0, m_irq[p]});
        if (m_rph == 1) check_output({tag, ".rdata"}, rd, m_rdata[p]);
    endtask

    always @(negedge ACLK) begin
        if (!ARESET) begin
            check_dut("d1", 0, if1.AWREADY, if1.WREADY, if1.BVALID, if1.BRESP, if1.ARREADY,
                      if1.RVALID, if1.RDATA, if1.RRESP, irq1);
            check_dut("d4", 1, if4.AWREADY, if4.WREADY, if4.BVALID, if4.BRESP, if4.ARREADY,
                      if4.RVALID, if4.RDATA, if4.RRESP, irq4);
        end
    end

    task automatic wait_wph(input int target, input string name);
        int t = 0;
        do begin @(negedge ACLK); t++; end while (m_wph != target && t < 40);
        if (m_wph != target) timeout_fail(name);
    endtask

    task automatic wait_rph(input int target, input string name);
        int t = 0;
        do begin @(negedge ACLK); t++; end while (m_rph != target && t < 40);
        if (m_rph != target) timeout_fail(name);
    endtask

    // Holds W back until the model says the next edge is the wanted timer event.
    function automatic bit hook_ok(input int h);
        case (h)
            1:       return m_en[0] && m_count[0] == 0;
            2:       return m_en[1] && m_phase[1] == 3;
            3:       return m_en[0] && m_count[0] == 3;
            default: return 1;
        endcase
    endfunction

    task automatic bus_write(input logic [15:0] addr, input logic [31:0] data, input int wdly,
                             input int bdly, input int hook, input bit stop_at_resp);
        int t = 0;
        @(negedge ACLK);
        aw_valid = 1; aw_addr = addr; aw_prot = 2'($urandom);
        wait_wph(1, "aw_accept");
        aw_valid = 0; aw_addr = 16'($urandom);
        repeat (wdly) @(negedge ACLK);
        while (!hook_ok(hook) && t < 64) begin @(negedge ACLK); t++; end
        if (!hook_ok(hook)) timeout_fail("w_hook");
        w_valid = 1; w_data = data; w_strb = 4'($urandom);
        wait_wph(2, "w_accept");
        w_valid = 0; w_data = $urandom;
        if (!stop_at_resp) begin
            repeat (bdly) @(negedge ACLK);
            b_ready = 1;
            wait_wph(0, "b_accept");
            b_ready = 0;
        end
    endtask

    task automatic bus_read(input logic [15:0] addr, input int rdly,
                            output logic [31:0] g1, output logic [31:0] g4);
        @(negedge ACLK);
        ar_valid = 1; ar_addr = addr; ar_prot = 2'($urandom);
        wait_rph(1, "ar_accept");
        ar_valid = 0; ar_addr = 16'($urandom);
        g1 = if1.RDATA; g4 = if4.RDATA;
        repeat (rdly) @(negedge ACLK);
        r_ready = 1;
        wait_rph(0, "r_accept");
        r_ready = 0;
    endtask

    task automatic wait_irq(input int p, input logic lvl, input string name, output int delta);
        int t = 0;
        while (((p == 0) ? irq1 : irq4) !== lvl && t < 80) begin @(negedge ACLK); t++; end
        if (((p == 0) ? irq1 : irq4) !== lvl) begin timeout_fail(name); delta = -1; end
        else delta = cyc - wfire_cyc;
    endtask

    task automatic do_reset();
        @(negedge ACLK); #2 ARESET = 1;
        repeat (3) @(negedge ACLK);
        #2 ARESET = 0;
        repeat (5) @(negedge ACLK);
    endtask

    function automatic logic [31:0] rand_data(input logic [15:0] a);
        case (a)
            16'h0000: return 32'($urandom_range(0, 7)) | ($urandom & 32'hFFFF_FFF8);
            16'h0004: return 32'($urandom_range(0, 6));
            16'h0008: return 32'($urandom_range(0, 9));
            default:  return $urandom;
        endcase
    endfunction

    task automatic apply_stimulus(input int n);
        logic [15:0] addrs [6] = '{16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h0010, 16'h0020};
        logic [31:0] r1, r4;
        for (int i = 0; i < n; i++) begin
            logic [15:0] wa, ra;
            int kind;
            wa   = addrs[$urandom_range(0, 5)];
            ra   = addrs[$urandom_range(0, 5)];
            kind = $urandom_range(0, 3);
            case (kind)
                0: bus_write(wa, rand_data(wa), $urandom_range(0, 3), $urandom_range(0, 3), 0, 0);
                1: bus_read(ra, $urandom_range(0, 3), r1, r4);
                2: fork
                       bus_write(wa, rand_data(wa), $urandom_range(0, 3), $urandom_range(0, 3), 0, 0);
                       bus_read(ra, $urandom_range(0, 3), r1, r4);
                   join
                default: repeat ($urandom_range(1, 8)) @(negedge ACLK);
            endcase
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no end of test, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [31:0] g1, g4;
    int          d;

    initial begin
        #1 ARESET = 1;
        repeat (3) @(negedge ACLK);
        #2 ARESET = 0;
        repeat (5) @(negedge ACLK);

        check_output("rst_awready", {31'b0, if1.AWREADY}, 32'd1);
        check_output("rst_arready", {31'b0, if4.ARREADY}, 32'd1);
        check_output("rst_bvalid",  {31'b0, if1.BVALID},  32'd0);
        check_output("rst_irq",     {31'b0, irq1 | irq4}, 32'd0);
        for (int i = 0; i <= 4; i++) begin
            bus_read(16'(i * 4), 0, g1, g4);
            check_output($sformatf("rst_rd_%0h.d1", i * 4), g1, 32'd0);
            check_output($sformatf("rst_rd_%0h.d4", i * 4), g4, 32'd0);
        end

        $display("[TB] periodic reload, LOADR=3 COUNTR=3 CTRLR=7");
        bus_write(16'h0004, 32'd3, 0, 0, 0, 0);
        bus_write(16'h0008, 32'd3, 0, 0, 0, 0);
        bus_write(16'h0000, 32'd7, 0, 0, 0, 0);
        check_output("model_cnt_a", m_count[0], 32'd2);
        @(negedge ACLK); check_output("model_cnt_b", m_count[0], 32'd1);
        @(negedge ACLK); check_output("model_cnt_c", m_count[0], 32'd0);
        @(negedge ACLK); check_output("model_cnt_d", m_count[0], 32'd3);
        check_output("model_exp", {31'b0, m_exp[0]}, 32'd1);
        wait_irq(0, 1'b1, "p1_irq_rise", d);
        check_output("p1_irq_latency", d, 32'd5);
        wait_irq(1, 1'b1, "p4_irq_rise", d);
        check_output("p4_irq_latency", d, 32'd17);

        bus_write(16'h000C, 32'd1, 0, 0, 3, 0);
        wait_irq(0, 1'b0, "p1_irq_clear", d);
        wait_irq(0, 1'b1, "p1_irq_reassert", d);
        check_output("p1_irq_reassert_lvl", {31'b0, irq1}, 32'd1);

        $display("[TB] clear collides with expiry");
        bus_write(16'h000C, 32'd1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            check_output("collide_irq", {31'b0, irq1}, 32'd1);
        end
        bus_read(16'h000C, 0, g1, g4);
        check_output("collide_exp", g1, 32'd1);

        bus_write(16'h0008, 32'h10, 0, 0, 2, 0);
        bus_read(16'h0008, 0, g1, g4);
        check_output("cnt_write_wins", g4, 32'h10);

        bus_write(16'h0020, 32'hFFFF_FFFF, 0, 0, 0, 0);
        bus_read(16'h0004, 0, g1, g4);
        check_output("bad_addr_load.d1", g1, 32'd3);
        check_output("bad_addr_load.d4", g4, 32'd3);
        bus_read(16'h0000, 0, g1, g4);
        check_output("bad_addr_ctrl", g1, 32'd7);
        bus_read(16'h0020, 1, g1, g4);
        check_output("bad_addr_read", g4, 32'd0);

        $display("[TB] one-shot, COUNTR=2 CTRLR=5");
        bus_write(16'h0000, 32'd0, 0, 0, 0, 0);
        bus_write(16'h000C, 32'd1, 0, 0, 0, 0);
        bus_write(16'h0008, 32'd2, 0, 0, 0, 0);
        bus_write(16'h0000, 32'd5, 0, 0, 0, 0);
        wait_irq(0, 1'b1, "os1_irq", d);
        check_output("os1_irq_latency", d, 32'd4);
        wait_irq(1, 1'b1, "os4_irq", d);
        check_output("os4_irq_latency", d, 32'd13);
        bus_read(16'h0000, 0, g1, g4);
        check_output("os_ctrl.d1", g1, 32'h4);
        check_output("os_ctrl.d4", g4, 32'h4);
        bus_read(16'h0008, 0, g1, g4);
        check_output("os_count.d1", g1, 32'd0);
        check_output("os_count.d4", g4, 32'd0);

        $display("[TB] randomized traffic");
        apply_stimulus(300);

        $display("[TB] reset during write response");
        bus_write(16'h0008, 32'd5, 0, 0, 0, 0);
        bus_write(16'h0004, 32'd9, 0, 0, 0, 1);
        check_output("pre_rst_bvalid", {31'b0, if1.BVALID}, 32'd1);
        #2 ARESET = 1;
        #1;
        check_output("async_bvalid.d1", {31'b0, if1.BVALID}, 32'd0);
        check_output("async_bvalid.d4", {31'b0, if4.BVALID}, 32'd0);
        repeat (2) @(negedge ACLK);
        #2 ARESET = 0;
        repeat (5) @(negedge ACLK);
        for (int i = 0; i < 4; i++) begin
            bus_read(16'(i * 4), 0, g1, g4);
            check_output($sformatf("post_rst_%0h.d1", i * 4), g1, 32'd0);
            check_output($sformatf("post_rst_%0h.d4", i * 4), g4, 32'd0);
        end

        repeat (2) @(negedge ACLK);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/trivial_timer.md
Name: trivial_timer

Overview:
- AXI4-Lite programmable down-counting timer with one level-triggered, active-high interrupt output.
- Intended to drive one irqN input of the trivial PLIC directly; irq holds high until software clears it.
- Register interface and handshake style match the PLIC: 16-bit addresses, fixed OKAY responses, no native-bus port.

Parameters:
PRESCALE, 1, ACLK cycles per timer tick; legal range 1..65536.

Ports:
ACLK  input  1  clock; all logic on posedge.
ARESET  input  1  reset, asynchronous, active-high.
irq  output  1  interrupt request to PLIC; level, active high.
AWVALID  input  1  write address valid.
AWREADY  output  1  write address ready.
AWADDR  input  16  write address.
AWPROT  input  2  ignored.
WVALID  input  1  write data valid.
WREADY  output  1  write data ready.
WDATA  input  32  write data.
WSTRB  input  4  ignored; every write is a full word.
BVALID  output  1  write response valid.
BREADY  input  1  write response ready.
BRESP  output  3  constant 0 (OKAY).
ARVALID  input  1  read address valid.
ARREADY  output  1  read address ready.
ARADDR  input  16  read address.
ARPROT  input  2  ignored.
RVALID  output  1  read data valid.
RREADY  input  1  read data ready.
RDATA  output  32  read data.
RRESP  output  3  constant 0 (OKAY).

Behaviour:
- Registers (all other addresses read 0, writes ignored, response OKAY):
  - 0x0000 CTRLR: bit0 EN, bit1 RELOAD, bit2 IE. Bits 31:3 read 0.
  - 0x0004 LOADR: 32-bit reload value.
  - 0x0008 COUNTR: current count, read/write.
  - 0x000C STATUSR: bit0 EXP, sticky; writing 1 clears it, writing 0 has no effect.
- Reset (async assert, sync deassert inside the block):
  - All registers, prescaler, RDATA and irq go to 0.
  - Both state machines go to IDLE, so AWREADY=ARREADY=1 and WREADY=BVALID=RVALID=0.
  - A reset mid-transaction drops the transaction; no response is issued.
- Write FSM:
  - IDLE (AWREADY=1): on AWVALID, latch AWADDR and go to DATA.
  - DATA (WREADY=1): on WVALID, register write takes effect at this clock edge; go to RESP.
  - RESP (BVALID=1): on BREADY, go to IDLE.
  - Minimum 3 cycles per write. AW and W are never accepted in the same cycle.
- Read FSM:
  - IDLE (ARREADY=1): on ARVALID, capture the register value into RDATA and go to DATA.
  - DATA (RVALID=1): on RREADY, go to IDLE.
  - RDATA holds the sampled value while RVALID=1. Reads have no side effects.
- Prescaler and tick:
  - Prescaler counts 0..PRESCALE-1 while EN=1, and holds at 0 while EN=0.
  - tick is asserted in the cycle where prescaler==PRESCALE-1 and EN=1. With PRESCALE=1, tick is asserted every EN cycle.
- Counting, on each tick:
  - If COUNTR!=0: COUNTR decrements by 1.
  - If COUNTR==0: EXP is set. Then, if RELOAD=1, COUNTR loads LOADR; otherwise COUNTR stays 0 and EN clears to 0 (one-shot).
  - Period with RELOAD=1 is (LOADR+1)*PRESCALE cycles.
- irq is registered: irq <= EXP & IE, so irq rises one cycle after EXP is set.
- Simultaneous events:
  - A software write to COUNTR in the same cycle as a tick wins; the decrement/reload is discarded.
  - A STATUSR clear in the same cycle as an expiry tick: the set wins, EXP stays 1.
  - A CTRLR write in the same cycle as a one-shot expiry: the written EN wins.
  - Writing EN 0->1 resets the prescaler to 0. Writing EN=0 freezes COUNTR.
- LOADR writes never affect COUNTR directly. Software programs COUNTR explicitly.
- No arithmetic wrap: COUNTR never decrements below 0.

Test Plan:
- Reset, then idle: AWREADY=ARREADY=1, BVALID=RVALID=0, irq=0. Reads of 0x0/0x4/0x8/0xC/0x10 all return 0.
- PRESCALE=1, LOADR=3, COUNTR=3, then CTRLR=0x7: EXP sets every 4 cycles, COUNTR sequence 3,2,1,0,3. irq=1 one cycle after the first EXP and stays 1 until a STATUSR write of 1; it re-asserts on the next expiry.
- One-shot, PRESCALE=4, COUNTR=2, CTRLR=0x5: EXP sets 12 cycles after the EN write edge. A CTRLR read then returns 0x4 (EN cleared) and COUNTR reads 0.
- Clear collision: STATUSR write of 1 lands on the same edge as an expiry tick -> EXP stays 1 and irq stays 1.
- COUNTR write of 0x10 on a tick edge -> COUNTR reads 0x10, not 0xF. Write to 0x20 -> BRESP=0, no register changes.
- ARESET pulse while BVALID=1 and COUNTR=5 -> BVALID drops immediately (async), and all registers read 0 after release.
